// File: rtl/mem_stage_sram.sv
// mem_stage_sram: ARM memory stage with a multi-cycle SRAM controller
module mem_stage_sram #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 17,
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_en_in,
  input  logic              MEM_r_en_in,
  input  logic              MEM_w_en_in,
  input  logic [3:0]        dest_in,
  input  logic [31:0]       alu_res_in,
  input  logic [DATA_W-1:0] val_rm,
  output logic              WB_en_out,
  output logic              MEM_r_en_out,
  output logic [3:0]        dest_out,
  output logic [31:0]       alu_res_out,
  output logic [DATA_W-1:0] data_mem_out,
  output logic              ready,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  inout  wire  [DATA_W-1:0] SRAM_DQ
);
  localparam int SH = $clog2(DATA_W / 8);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] word;
  logic wr, req, last;
  assign req = MEM_r_en_in | MEM_w_en_in;
  assign word = (alu_res_in - 32'(BASE_ADDR)) >> SH;
  assign last = cnt == CW'(WAIT_CYCLES - 1);
  assign WB_en_out = WB_en_in;
  assign MEM_r_en_out = MEM_r_en_in;
  assign dest_out = dest_in;
  assign alu_res_out = alu_res_in;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ = (state == ACCESS && wr) ? val_rm : 'z;
  // next state, stall and active-low strobes
  always_comb begin
    state_n = state == IDLE ? (req ? ACCESS : IDLE) : state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
    ready = (state == IDLE && !req) || state == DONE;
    SRAM_CE_N = state != ACCESS;
    SRAM_WE_N = !(state == ACCESS && wr);
    SRAM_OE_N = !(state == ACCESS && !wr);
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // latch the request on acceptance, count wait states, capture read data on the last access cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      wr <= 1'b0;
      SRAM_ADDR <= '0;
      data_mem_out <= '0;
    end else if (state == IDLE && req) begin
      cnt <= '0;
      wr <= MEM_w_en_in;
      SRAM_ADDR <= ADDR_W'(word);
    end else if (state == ACCESS) begin
      cnt <= cnt + 1'b1;
      if (last && !wr) data_mem_out <= SRAM_DQ;
    end
  end
endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: vector table plus scoreboard bench for mem_stage_sram
module tb_mem_stage_sram;
  localparam int W = 5;
  localparam logic [31:0] PROBE = 32'h5A5A5A5A;
  typedef struct {
    logic wr, rd;
    logic [31:0] alu, val, exp_dmem;
    logic [16:0] exp_addr;
  } vec_t;
  logic clk = 0, rst = 1;
  logic wb_en = 0, r_en = 0, w_en = 0;
  logic [3:0] dest = 0;
  logic [31:0] alu = 0, val = 0;
  logic wb_o, r_o, ready, we_n, oe_n, ce_n, ub_n, lb_n;
  logic [3:0] dest_o;
  logic [31:0] alu_o, dmem;
  logic [16:0] addr;
  wire [31:0] dq;
  logic [31:0] mem [0:(1<<17)-1];
  logic v_r = 0;
  logic [31:0] v_alu = 0;
  logic [15:0] v_val = 0, v_dmem;
  logic v_wb_o, v_r_o, v_ready, v_we_n, v_oe_n, v_ce_n, v_ub_n, v_lb_n;
  logic [3:0] v_dest_o;
  logic [31:0] v_alu_o;
  logic [16:0] v_addr;
  wire [15:0] v_dq;
  int total = 0, bad = 0;
  logic [31:0] sb [$];
  vec_t vt [10];

  always #5 clk = ~clk;

  mem_stage_sram dut (
    .clk(clk), .rst(rst), .WB_en_in(wb_en), .MEM_r_en_in(r_en), .MEM_w_en_in(w_en),
    .dest_in(dest), .alu_res_in(alu), .val_rm(val), .WB_en_out(wb_o), .MEM_r_en_out(r_o),
    .dest_out(dest_o), .alu_res_out(alu_o), .data_mem_out(dmem), .ready(ready),
    .SRAM_ADDR(addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_DQ(dq)
  );

  mem_stage_sram #(.DATA_W(16), .ADDR_W(17), .WAIT_CYCLES(1), .BASE_ADDR(0)) u_v (
    .clk(clk), .rst(rst), .WB_en_in(1'b0), .MEM_r_en_in(v_r), .MEM_w_en_in(1'b0),
    .dest_in(4'd0), .alu_res_in(v_alu), .val_rm(v_val), .WB_en_out(v_wb_o), .MEM_r_en_out(v_r_o),
    .dest_out(v_dest_o), .alu_res_out(v_alu_o), .data_mem_out(v_dmem), .ready(v_ready),
    .SRAM_ADDR(v_addr), .SRAM_WE_N(v_we_n), .SRAM_OE_N(v_oe_n), .SRAM_CE_N(v_ce_n),
    .SRAM_UB_N(v_ub_n), .SRAM_LB_N(v_lb_n), .SRAM_DQ(v_dq)
  );

  // SRAM model: probe pattern while deselected so any stray DUT drive shows up
  assign dq = ce_n ? PROBE : (!oe_n ? mem[addr] : 'z);
  assign v_dq = (!v_oe_n && !v_ce_n) ? 16'h4C30 + 16'(v_addr) : 'z;
  always @(posedge clk) if (!ce_n && !we_n) mem[addr] <= dq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_access(input vec_t v);
    logic acc;
    @(posedge clk); #1;
    w_en = v.wr; r_en = v.rd; alu = v.alu; val = v.val; dest = v.alu[3:0]; wb_en = v.rd;
    sb.push_back(v.exp_dmem);
    for (int c = 0; c <= W + 1; c++) begin
      @(negedge clk);
      acc = c >= 1 && c <= W;
      chk($sformatf("strobes %h c%0d", v.alu, c), {28'd0, ready, ce_n, we_n, oe_n},
          {28'd0, c == W + 1, !acc, !(acc && v.wr), !(acc && !v.wr)});
      chk($sformatf("pass %h c%0d", v.alu, c), {alu_o[27:0], dest_o}, {v.alu[27:0], v.alu[3:0]});
      if (!acc) chk($sformatf("dq hiz %h c%0d", v.alu, c), dq, PROBE);
      else if (v.wr) chk($sformatf("dq wr %h c%0d", v.alu, c), dq, v.val);
      if (c >= 1) chk($sformatf("addr %h c%0d", v.alu, c), {15'd0, addr}, {15'd0, v.exp_addr});
    end
    if (sb.size() == 0) chk("sb empty", 32'd1, 32'd0);
    else chk($sformatf("dmem %h", v.alu), dmem, sb.pop_front());
  endtask

  initial begin
    vt[0] = '{1, 0, 1036, 32'h13579BDF, 32'h0, 17'd3};
    vt[1] = '{1, 0, 1028, 32'hDEADBEEF, 32'h0, 17'd1};
    vt[2] = '{0, 1, 1028, 32'h0, 32'hDEADBEEF, 17'd1};
    vt[3] = '{1, 0, 1032, 32'hCAFEF00D, 32'hDEADBEEF, 17'd2};
    vt[4] = '{0, 1, 1036, 32'h0, 32'h13579BDF, 17'd3};
    vt[5] = '{0, 1, 1030, 32'h0, 32'hDEADBEEF, 17'd1};
    vt[6] = '{1, 0, 0, 32'h0BADC0DE, 32'hDEADBEEF, 17'h1FF00};
    vt[7] = '{0, 1, 0, 32'h0, 32'h0BADC0DE, 17'h1FF00};
    vt[8] = '{1, 1, 1040, 32'h11112222, 32'h0BADC0DE, 17'd4};
    vt[9] = '{0, 1, 1040, 32'h0, 32'h11112222, 17'd4};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst strobes", {28'd0, ready, ce_n, we_n, oe_n}, 32'hF);
    chk("rst addr", {15'd0, addr}, 32'd0);
    chk("rst dmem", dmem, 32'd0);
    chk("rst dq", dq, PROBE);
    #1 rst = 0; alu = 32'h1234; dest = 7; wb_en = 1;
    @(negedge clk);
    chk("idle alu", alu_o, 32'h1234);
    chk("idle dest", {28'd0, dest_o}, 32'd7);
    chk("idle wb", {31'd0, wb_o}, 32'd1);
    chk("idle strobes", {28'd0, ready, ce_n, we_n, oe_n}, 32'hF);
    chk("idle dq", dq, PROBE);
    for (int i = 0; i < 10; i++) run_access(vt[i]);
    @(posedge clk); #1;
    w_en = 1; r_en = 0; alu = 1044; val = 32'h77778888;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0; w_en = 0; alu = 0; val = 0;
    @(negedge clk);
    chk("abort strobes", {28'd0, ready, ce_n, we_n, oe_n}, 32'hF);
    chk("abort dq", dq, PROBE);
    chk("abort dmem", dmem, 32'd0);
    chk("abort addr", {15'd0, addr}, 32'd0);
    run_access('{0, 1, 1028, 32'h0, 32'hDEADBEEF, 17'd1});
    @(posedge clk); #1;
    r_en = 0; w_en = 0;
    v_r = 1; v_alu = 6;
    @(negedge clk);
    chk("v c0", {28'd0, v_ready, v_ce_n, v_we_n, v_oe_n}, 32'h7);
    @(negedge clk);
    chk("v c1", {28'd0, v_ready, v_ce_n, v_we_n, v_oe_n}, 32'h2);
    chk("v addr", {15'd0, v_addr}, 32'd3);
    @(negedge clk);
    chk("v c2", {28'd0, v_ready, v_ce_n, v_we_n, v_oe_n}, 32'hF);
    chk("v dmem", {16'd0, v_dmem}, 32'h4C33);
    @(posedge clk); #1 v_r = 0;
    chk("sb drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
